// File: rtl/i2s_stereo_rx.sv
// i2s_stereo_rx: I2S receiver for the MT32pi audio link. It synchronizes and
// debounces the asynchronous bclk/ws/data pins, deserializes left-aligned
// words, and emits an atomic L/R pair with a one-cycle valid strobe. If bclk
// stops for TIMEOUT cycles, the outputs are muted and the link drops.
module i2s_stereo_rx #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bclk_in,
  input  logic             ws_in,
  input  logic             data_in,
  output logic [WIDTH-1:0] sample_l,
  output logic [WIDTH-1:0] sample_r,
  output logic             sample_valid,
  output logic             active
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CMAX  = CW'(WIDTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [1:0]       bclk_sy, ws_sy, data_sy;
  logic             bclk_p, bclk_db, bclk_dq;
  logic             bclk_edge;
  logic             ws, data;

  logic [WIDTH-1:0] sbuf, held_l, word, ins;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    tcnt;
  logic             ws_prev, ws_seen, synced;

  // Two-flop synchronizers on all three pins. bclk is also debounced: its
  // level moves only after two consecutive synchronized samples agree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sy <= '0;
      ws_sy   <= '0;
      data_sy <= '0;
      bclk_p  <= 1'b0;
      bclk_db <= 1'b0;
      bclk_dq <= 1'b0;
    end else begin
      bclk_sy <= {bclk_sy[0], bclk_in};
      ws_sy   <= {ws_sy[0], ws_in};
      data_sy <= {data_sy[0], data_in};
      bclk_p  <= bclk_sy[1];
      if (bclk_sy[1] == bclk_p) bclk_db <= bclk_sy[1];
      bclk_dq <= bclk_db;
    end
  end

  assign bclk_edge = bclk_db & ~bclk_dq;
  assign ws        = ws_sy[1];
  assign data      = data_sy[1];

  // The word as it would stand after storing the current bit. Bits past
  // WIDTH are dropped, and unfilled LSBs stay zero.
  always_comb begin
    ins  = {data, {(WIDTH-1){1'b0}}} >> cnt;
    word = sbuf;
    if (cnt < CMAX) word = sbuf | ins;
  end

  // Serial capture, word-boundary handling, pair commit, and link timeout.
  // ws_seen makes the first edge after reset or timeout only record ws. This
  // keeps a mid-word restart from looking like a boundary and committing a
  // partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      active       <= 1'b0;
      sbuf         <= '0;
      held_l       <= '0;
      cnt          <= '0;
      tcnt         <= '0;
      ws_prev      <= 1'b0;
      ws_seen      <= 1'b0;
      synced       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (bclk_edge) begin
        tcnt <= '0;
        if (!ws_seen) begin
          ws_seen <= 1'b1;
          ws_prev <= ws;
        end else if (ws == ws_prev) begin
          sbuf <= word;
          if (cnt < CMAX) cnt <= cnt + 1'b1;
        end else begin
          // Boundary: this bit is the ending word's LSB and is already in 'word'.
          ws_prev <= ws;
          if (synced) begin
            if (!ws_prev) begin
              held_l <= word;
            end else begin
              sample_l     <= held_l;
              sample_r     <= word;
              sample_valid <= 1'b1;
              active       <= 1'b1;
            end
          end else begin
            held_l <= '0;
          end
          sbuf   <= '0;
          cnt    <= '0;
          synced <= 1'b1;
        end
      end else if (tcnt == TLAST) begin
        // Link dead: mute and force a fresh alignment when bclk returns.
        active   <= 1'b0;
        sample_l <= '0;
        sample_r <= '0;
        synced   <= 1'b0;
        ws_seen  <= 1'b0;
        held_l   <= '0;
        sbuf     <= '0;
        cnt      <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_stereo_rx.sv
// Directed bench for i2s_stereo_rx. It generates standard I2S frames, where
// ws leads data by one bit, at 8 clk per bit, and checks them with
// immediate assertions.
module tb_i2s_stereo_rx;
  localparam int W  = 16;
  localparam int TO = 64;

  logic         clk = 1'b0, reset = 1'b0;
  logic         bclk_in = 1'b0, ws_in = 1'b0, data_in = 1'b0;
  logic [W-1:0] sample_l, sample_r;
  logic         sample_valid, active;

  int   cyc = 0, npulse = 0, total = 0, bad = 0, last_rise = 0;
  int   p0, t0;
  logic last_data = 1'b0;

  i2s_stereo_rx #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bclk_in(bclk_in), .ws_in(ws_in),
    .data_in(data_in), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .active(active)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter and valid-pulse counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sample_valid === 1'b1) npulse <= npulse + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One bit slot: low phase (optional 1-clk glitch), then rising edge.
  task automatic slot(input logic w, input logic d, input bit gl);
    ws_in = w; data_in = d; bclk_in = 1'b0;
    @(negedge clk);
    if (gl) bclk_in = 1'b1;
    @(negedge clk);
    bclk_in = 1'b0;
    repeat (2) @(negedge clk);
    bclk_in = 1'b1;
    last_rise = cyc;
    repeat (4) @(negedge clk);
  endtask

  // ns slots of one channel. The data driven in each slot is the previous
  // slot's bit, giving I2S's one-bit ws lead.
  task automatic send_ch(input logic w, input logic [15:0] v, input int ns, input bit gl);
    logic [15:0] t;
    t = v;
    for (int i = 0; i < ns; i++) begin
      slot(w, last_data, gl);
      last_data = t[15];
      t = t << 1;
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int nb, input bit gl);
    send_ch(1'b0, l, nb, gl);
    send_ch(1'b1, r, nb, gl);
  endtask

  task automatic do_reset();
    bclk_in = 1'b0; ws_in = 1'b0; data_in = 1'b0; last_data = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_l", 32'(sample_l), 32'h0);
    chk("rst_r", 32'(sample_r), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_active", 32'(active), 32'h0);

    // 32-bit slots: the trailing 16 bits are dropped, and the first frame only aligns
    p0 = npulse;
    frame(16'h1234, 16'hABCD, 32, 1'b0);
    chk("t1_first_frame_pulses", 32'(npulse - p0), 32'd0);
    frame(16'h1234, 16'hABCD, 32, 1'b0);
    frame(16'h1234, 16'hABCD, 32, 1'b0);
    chk("t1_pulses", 32'(npulse - p0), 32'd2);
    chk("t1_l", 32'(sample_l), 32'h1234);
    chk("t1_r", 32'(sample_r), 32'hABCD);
    chk("t1_active", 32'(active), 32'h1);

    // Exact 16-bit words
    do_reset();
    p0 = npulse;
    repeat (3) frame(16'h8001, 16'h7FFE, 16, 1'b0);
    chk("t2_pulses", 32'(npulse - p0), 32'd2);
    chk("t2_l", 32'(sample_l), 32'h8001);
    chk("t2_r", 32'(sample_r), 32'h7FFE);

    // 12-bit words are zero-padded in the LSBs
    do_reset();
    repeat (3) frame(16'hABC0, 16'h5550, 12, 1'b0);
    chk("t3_l", 32'(sample_l), 32'hABC0);
    chk("t3_r", 32'(sample_r), 32'h5550);

    // Timeout: stop bclk mid-word
    do_reset();
    repeat (2) frame(16'h1111, 16'h2222, 16, 1'b0);
    send_ch(1'b0, 16'h1111, 5, 1'b0);
    chk("t4_l_before", 32'(sample_l), 32'h1111);
    p0 = npulse;
    t0 = -1;
    for (int k = 0; k < TO + 50; k++) begin
      if (active === 1'b0) begin t0 = cyc; break; end
      @(negedge clk);
    end
    // The counter starts after a fixed 5-cycle sync+debounce+edge latency.
    chk("t4_fall_delay", 32'(t0 - last_rise), 32'(TO + 5));
    chk("t4_active", 32'(active), 32'h0);
    chk("t4_l_muted", 32'(sample_l), 32'h0);
    chk("t4_r_muted", 32'(sample_r), 32'h0);
    repeat (10) @(negedge clk);
    chk("t4_no_pulse", 32'(npulse - p0), 32'd0);
    p0 = npulse;
    repeat (3) frame(16'h3333, 16'h4444, 16, 1'b0);
    chk("t4_resume_pulses", 32'(npulse - p0), 32'd2);
    chk("t4_resume_l", 32'(sample_l), 32'h3333);
    chk("t4_resume_r", 32'(sample_r), 32'h4444);

    // Glitches on bclk must not add captures
    do_reset();
    p0 = npulse;
    repeat (3) frame(16'h1234, 16'hABCD, 16, 1'b1);
    chk("t5_pulses", 32'(npulse - p0), 32'd2);
    chk("t5_l", 32'(sample_l), 32'h1234);
    chk("t5_r", 32'(sample_r), 32'hABCD);

    // One-cycle reset mid-right-word
    send_ch(1'b0, 16'h5678, 16, 1'b0);
    send_ch(1'b1, 16'h9ABC, 6, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_l", 32'(sample_l), 32'h0);
    chk("t6_r", 32'(sample_r), 32'h0);
    chk("t6_valid", 32'(sample_valid), 32'h0);
    chk("t6_active", 32'(active), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    p0 = npulse;
    send_ch(1'b1, 16'h9ABC, 10, 1'b0);
    chk("t6_no_partial", 32'(npulse - p0), 32'd0);
    repeat (3) frame(16'h0F0F, 16'hF0F0, 16, 1'b0);
    chk("t6_pulses", 32'(npulse - p0), 32'd2);
    chk("t6_l_resync", 32'(sample_l), 32'h0F0F);
    chk("t6_r_resync", 32'(sample_r), 32'hF0F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
